// File: rtl/md_controller.sv
// md_controller: sequencer for the shared multiply/divide unit and the HI/LO register pair.
// Define MD_MADD_EN to enable the accumulate ops (madd/maddu/msub/msubu, md_op 7-10).
module md_controller #(
    parameter int unsigned MULT_CYCLES = 5,   // legal range 1..15
    parameter int unsigned DIV_CYCLES  = 10   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MUL_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] pend_q;
    logic        pend_dz_q;

    logic is_mul;
    logic is_div;
    logic is_mthi;
    logic is_mtlo;
    logic op_signed;
`ifdef MD_MADD_EN
    logic is_acc;
    logic acc_sub;
    logic pend_acc_q;
    logic pend_sub_q;
    logic [63:0] acc_d;
`endif

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        op_signed = 1'b0;
`ifdef MD_MADD_EN
        is_acc    = 1'b0;
        acc_sub   = 1'b0;
`endif
        case (md_op)
            OP_MULT:  begin is_mul = 1'b1; op_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; op_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; acc_sub = 1'b1; op_signed = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; acc_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // One 64x64 multiplier truncated to 64 bits serves both signednesses via extension.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod_d;
    assign mul_a  = {{32{op_signed & rs_val[31]}}, rs_val};
    assign mul_b  = {{32{op_signed & rt_val[31]}}, rt_val};
    assign prod_d = mul_a * mul_b;

    // Divide by 1 for the zero and signed-overflow cases: gives 0x80000000 rem 0 for the latter.
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] divisor;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    assign div_zero = (rt_val == 32'd0);
    assign div_ovf  = op_signed && (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign divisor  = (div_zero || div_ovf) ? 32'd1 : rt_val;

    always_comb begin
        if (op_signed) begin
            quo_d = $signed(rs_val) / $signed(divisor);
            rem_d = $signed(rs_val) % $signed(divisor);
        end else begin
            quo_d = rs_val / divisor;
            rem_d = rs_val % divisor;
        end
    end

`ifdef MD_MADD_EN
    // Accumulation reads HI/LO as they stand at the commit edge.
    assign acc_d = pend_sub_q ? ({hi_q, lo_q} - pend_q) : ({hi_q, lo_q} + pend_q);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_q     <= 64'd0;
            pend_dz_q  <= 1'b0;
`ifdef MD_MADD_EN
            pend_acc_q <= 1'b0;
            pend_sub_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state_q    <= S_MUL;
                            cnt_q      <= MUL_LAT;
                            busy_q     <= 1'b1;
                            pend_q     <= prod_d;
                            pend_dz_q  <= 1'b0;
`ifdef MD_MADD_EN
                            pend_acc_q <= is_acc;
                            pend_sub_q <= acc_sub;
`endif
                        end else if (is_div) begin
                            state_q    <= S_DIV;
                            cnt_q      <= DIV_LAT;
                            busy_q     <= 1'b1;
                            pend_q     <= {rem_d, quo_d};
                            pend_dz_q  <= div_zero;
`ifdef MD_MADD_EN
                            pend_acc_q <= 1'b0;
                            pend_sub_q <= 1'b0;
`endif
                        end else if (is_mthi) begin
                            hi_q   <= rs_val;
                            done_q <= 1'b1;
                        end else if (is_mtlo) begin
                            lo_q   <= rs_val;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    // start is deliberately not looked at here: requests while busy are dropped.
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (pend_dz_q) begin
                            dz_q <= 1'b1;
                        end
`ifdef MD_MADD_EN
                        else if (pend_acc_q) begin
                            {hi_q, lo_q} <= acc_d;
                        end
`endif
                        else begin
                            hi_q <= pend_q[63:32];
                            lo_q <= pend_q[31:0];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_controller.sv
// Table-driven bench for md_controller with a scoreboard of expected HI/LO/dz/latency per op.
module tb_md_controller;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    md_controller #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    // lat: >0 busy cycles, 0 = mthi/mtlo (immediate), -1 = no effect
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edz;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int lat, input int inj);
        exp_t e;
        int   n;
        sb.push_back('{name, ehi, elo, edz});
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        // Scramble operands so an unlatched implementation shows up.
        start = 1'b0; md_op = 4'd0; rs_val = 32'hDEAD_BEEF; rt_val = 32'd0;
        if (lat == 0) begin
            chk({name, ".done"}, 64'(done), 64'd1);
            chk({name, ".busy"}, 64'(busy), 64'd0);
        end else begin
            chk({name, ".done_e0"}, 64'(done), 64'd0);
        end
        if (lat > 0) begin
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                chk({name, ".busy"}, 64'(busy), 64'd1);
                if (n == inj) begin
                    start = 1'b1; md_op = 4'd3; rs_val = 32'h1234; rt_val = 32'd0;
                end
                @(posedge clk); #1;
                start = 1'b0; md_op = 4'd0;
                n++;
            end
            chk({name, ".lat"}, 64'(n), 64'(lat));
            chk({name, ".busy_end"}, 64'(busy), 64'd0);
        end else if (lat < 0) begin
            chk({name, ".busy"}, 64'(busy), 64'd0);
        end
        e = sb.pop_front();
        chk({e.name, ".hi"}, 64'(hi), 64'(e.ehi));
        chk({e.name, ".lo"}, 64'(lo), 64'(e.elo));
        chk({e.name, ".dz"}, 64'(dz), 64'(e.edz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset_n = 1'b0; start = 1'b0; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dz",   64'(dz),   64'd0);
        chk("rst.hi",   64'(hi),   64'd0);
        chk("rst.lo",   64'(lo),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        vecs.push_back('{"mult_neg",   4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 5});
        vecs.push_back('{"multu_max",  4'd2, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE, 1'b0, 5});
        vecs.push_back('{"div_b2b",    4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 10});
        vecs.push_back('{"mthi",       4'd5, 32'h11,        32'h99,       32'h11,        32'hFFFF_FFFD, 1'b0, 0});
        vecs.push_back('{"mtlo",       4'd6, 32'h22,        32'h99,       32'h11,        32'h22,        1'b0, 0});
        vecs.push_back('{"divu_zero",  4'd4, 32'd5,         32'd0,        32'h11,        32'h22,        1'b1, 10});
        vecs.push_back('{"div_ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 10});
        vecs.push_back('{"divu",       4'd4, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 10});
        vecs.push_back('{"div_negdvs", 4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 10});
        vecs.push_back('{"op_none",    4'd0, 32'h55,        32'h66,       32'd1,         32'hFFFF_FFFD, 1'b0, -1});
        vecs.push_back('{"op_15",      4'd15, 32'h55,       32'h66,       32'd1,         32'hFFFF_FFFD, 1'b0, -1});
        vecs.push_back('{"mult_pmax",  4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1,        1'b0, 5});
        vecs.push_back('{"multu_big",  4'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0, 5});
`ifdef MD_MADD_EN
        vecs.push_back('{"mthi0",      4'd5, 32'd0,         32'd0,        32'd0,         32'd0,         1'b0, 0});
        vecs.push_back('{"mtlo10",     4'd6, 32'd10,        32'd0,        32'd0,         32'd10,        1'b0, 0});
        vecs.push_back('{"madd",       4'd7, 32'd3,         32'd4,        32'd0,         32'd22,        1'b0, 5});
        vecs.push_back('{"msubu22",    4'd10, 32'd1,        32'd22,       32'd0,         32'd0,         1'b0, 5});
        vecs.push_back('{"msubu1",     4'd10, 32'd1,        32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5});
        vecs.push_back('{"msub",       4'd9, 32'd2,         32'hFFFF_FFFF, 32'd0,        32'd1,         1'b0, 5});
        vecs.push_back('{"maddu",      4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2,        1'b0, 5});
`else
        vecs.push_back('{"op7_off",    4'd7, 32'd3,         32'd4,        32'h4000_0000, 32'h0,         1'b0, -1});
        vecs.push_back('{"op10_off",   4'd10, 32'd1,        32'd1,        32'h4000_0000, 32'h0,         1'b0, -1});
`endif

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].lat, -1);

        // A divide-by-zero request injected mid-mult must be dropped.
        run_op("mult_ign_start", 4'd1, 32'h10, 32'h20, 32'd0, 32'h200, 1'b0, 5, 2);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_mid.busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk("rst_mid.dz",   64'(dz),   64'd0);
        chk("rst_mid.hi",   64'(hi),   64'd0);
        chk("rst_mid.lo",   64'(lo),   64'd0);
        @(negedge clk) reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("rst_mid.no_commit", 64'(seen), 64'd0);
        chk("rst_mid.hi_after",  64'(hi),   64'd0);
        chk("rst_mid.lo_after",  64'(lo),   64'd0);

        run_op("mult_after_rst", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/md_controller.md
Name: md_controller

Overview:
- Sequencer for the shared multiply/divide resource and the HI/LO register pair.
- Accepts one MD operation per start pulse from the execute stage and holds `busy` for a fixed, parameterised latency.
- Commits results to HI/LO and pulses `done` at completion.
- Pipeline control uses `start | busy` to stall MD-dependent instructions (mult/div/mfhi/mflo/mthi/mtlo) in decode.

Parameters:
- MULT_CYCLES, 5, busy length for mult/multu (and madd family); legal range 1..15.
- DIV_CYCLES, 10, busy length for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; sampled on rising edge of clk.
- md_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; codes 7–10 are valid only with the optional feature; other codes are treated as none.
- rs_val  input  32  operand A (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  operand B (divisor / multiplier).
- busy  output  1  operation in flight; registered.
- done  output  1  one-cycle pulse after HI/LO commit; registered.
- dz  output  1  one-cycle pulse: division by zero detected; registered.
- hi  output  32  HI register; registered.
- lo  output  32  LO register; registered.

Behaviour:
- Reset: while reset_n=0, asynchronously force the following.
  - busy=0, done=0, dz=0, hi=0, lo=0.
  - State=IDLE, counter=0, pending result cleared.
  - Reset mid-operation aborts the operation; nothing is committed.
- States:
  - IDLE. On an edge with start=1 and a valid op:
    - mult/multu/madd family → MUL.
    - div/divu → DIV.
    - mthi/mtlo → stay IDLE; write hi or lo = rs_val on that same edge; busy stays 0; done pulses next cycle.
  - MUL/DIV: operands are latched at the start edge (E0). Counter loads MULT_CYCLES or DIV_CYCLES and decrements each edge.
  - busy=1 from E0 until edge E_N, N = latency. At E_N: busy→0, hi/lo committed, done=1 for exactly one cycle, state→IDLE.
  - start=1 in the cycle after E_N is accepted (back-to-back issue).
- start while busy=1: ignored entirely. No operand latch, no HI/LO write, no counter change. Pipeline stall guarantees this never happens; the bench checks it anyway.
- start=1 with md_op=0 or an illegal code: no effect.
- Arithmetic:
  - mult: 64-bit signed product. multu: unsigned product. {hi,lo} = product.
  - div: signed, truncating toward zero. lo = quotient, hi = remainder; remainder sign follows dividend.
  - divu: unsigned; same lo/hi assignment.
  - 0x80000000 / -1 (signed): lo=0x80000000, hi=0.
- Divide by zero (rt_val=0 at start):
  - Runs full DIV_CYCLES.
  - hi/lo unchanged at E_N.
  - done=1 and dz=1 together for one cycle.
- Result computation may be combinational at E0 into a pending register or iterative. Either way, the externally visible timing is exactly as above.
- hi/lo never change except at a commit edge or an mthi/mtlo edge.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: md_op 7–10 are valid and use MULT_CYCLES latency; results are read from hi/lo at the commit edge.
  - madd: {hi,lo} += signed product.
  - maddu: {hi,lo} += unsigned product.
  - msub: {hi,lo} −= signed product.
  - msubu: {hi,lo} −= unsigned product.
  - Accumulation is modulo 2^64.
- Undefined: codes 7–10 are illegal and have no effect; no accumulate hardware is synthesised.

Test Plan:
- mult: rs=0xFFFFFFFE (−2), rt=3, start at E0 → busy=1 for 5 cycles; at E5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; busy=0.
- multu and back-to-back div: multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE; start div −7/2 the cycle after done → 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu by zero: hi=0x11, lo=0x22 preset via mthi/mtlo (each visible after 1 edge, busy stays 0); divu rt=0 → after 10 cycles hi/lo unchanged; done=1 and dz=1 together.
- start while busy: during mult, assert start with div and other operands at cycle 2 → ignored; final hi/lo equal the mult result; busy length still 5.
- reset mid-op: reset_n low at cycle 3 of div (asynchronous, between edges) → outputs 0 immediately; after release, no late commit or done.
- MD_MADD_EN defined: hi/lo=0:10, madd 3×4 → lo=22; msubu 1×22 → lo=0; msubu 1×1 → hi=lo=0xFFFFFFFF. MD_MADD_EN undefined: op 7 → no busy, hi/lo unchanged.
